// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Two requesters share one ALU through a round-robin arbiter. Each accepted
//   operation runs through IDLE -> EXEC -> RESP. The response is held on the
//   rsp_* outputs until the consumer handshakes it. The bus then returns to
//   IDLE.
//
// Parameters
//   Ancho            operand/result width in bits (>= 2)
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   reqN_valid       requester N has an operation pending
//   reqN_ready       requester N accepted this cycle (combinational, IDLE only)
//   reqN_a/b         operands of requester N
//   reqN_op          ALU operation code (legal 4'h0-4'h9)
//   reqN_flagin      ALU flag input of requester N
//   rsp_valid        response held on rsp_*
//   rsp_ready        consumer accepts the response
//   rsp_id           requester that owns the response
//   rsp_result       registered ALU result
//   rsp_flags        registered ALU flag (carry / borrow / shifted-out bit)
//   rsp_zero         registered zero flag
//   rsp_err          illegal opcode was captured
//   grant_cnt0/1     saturating grant counters (only with ALU_ARB_STATS_EN)
//
// Configuration
//   ALU_ARB_STATS_EN  when defined, adds the grant_cnt0 / grant_cnt1 outputs
// -----------------------------------------------------------------------------

// Shared ALU. The opcode map is listed below:
//   0 ADD   a+b             flag = carry
//   1 ADDC  a+b+flagin      flag = carry
//   2 SUB   a-b             flag = borrow
//   3 SUBB  a-b-flagin      flag = borrow
//   4 AND   5 OR   6 XOR   7 NOT a      flag = 0
//   8 SHL   {a[W-2:0],flagin}           flag = a[W-1]
//   9 SHR   {flagin,a[W-1:1]}           flag = a[0]
module alu_arbiter_alu #(
  parameter int Ancho = 4
) (
  input  logic [Ancho-1:0] a,
  input  logic [Ancho-1:0] b,
  input  logic [3:0]       op,
  input  logic             flagin,
  output logic [Ancho-1:0] alu_result,
  output logic             alu_flags,
  output logic             z
);

  // One extra bit on top carries the flag for the arithmetic and shift ops.
  logic [Ancho:0] wide;

  always_comb begin
    wide = '0;
    unique case (op)
      4'h0: wide = {1'b0, a} + {1'b0, b};
      4'h1: wide = {1'b0, a} + {1'b0, b} + {{Ancho{1'b0}}, flagin};
      4'h2: wide = {1'b0, a} - {1'b0, b};
      4'h3: wide = {1'b0, a} - {1'b0, b} - {{Ancho{1'b0}}, flagin};
      4'h4: wide = {1'b0, a & b};
      4'h5: wide = {1'b0, a | b};
      4'h6: wide = {1'b0, a ^ b};
      4'h7: wide = {1'b0, ~a};
      4'h8: wide = {a, flagin};
      4'h9: wide = {a[0], flagin, a[Ancho-1:1]};
      default: wide = '0;
    endcase
  end

  assign alu_result = wide[Ancho-1:0];
  assign alu_flags  = wide[Ancho];
  assign z          = (wide[Ancho-1:0] == '0);

endmodule

module alu_arbiter #(
  parameter int Ancho = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [Ancho-1:0] req0_a,
  input  logic [Ancho-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req0_flagin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [Ancho-1:0] req1_a,
  input  logic [Ancho-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic             req1_flagin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [Ancho-1:0] rsp_result,
  output logic             rsp_flags,
  output logic             rsp_zero,
  output logic             rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [Ancho-1:0] cap_a;
  logic [Ancho-1:0] cap_b;
  logic [3:0]       cap_op;
  logic             cap_flagin;
  logic             cap_id;

  logic             grant;
  logic             grant_id;
  logic [Ancho-1:0] alu_result;
  logic             alu_flags;
  logic             alu_zero;
  logic             op_legal;

  // Arbitration. On contention, the requester that was not served last wins.
  // A lone requester always wins. rst_n is included so that no ready pulse
  // can leak while reset is asserted.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    grant      = rst_n && (state == IDLE) && !rsp_valid && (req0_valid || req1_valid);
    req0_ready = grant && !grant_id;
    req1_ready = grant && grant_id;
  end

  assign op_legal = (cap_op <= 4'h9);

  alu_arbiter_alu #(
    .Ancho(Ancho)
  ) u_alu (
    .a          (cap_a),
    .b          (cap_b),
    .op         (cap_op),
    .flagin     (cap_flagin),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .z          (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_flagin <= 1'b0;
      cap_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            cap_a      <= grant_id ? req1_a      : req0_a;
            cap_b      <= grant_id ? req1_b      : req0_b;
            cap_op     <= grant_id ? req1_op     : req0_op;
            cap_flagin <= grant_id ? req1_flagin : req0_flagin;
            cap_id     <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          if (op_legal) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else begin
            // Illegal opcodes bypass the ALU and report a zero result.
            rsp_result <= '0;
            rsp_flags  <= 1'b0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      if (req0_ready && (grant_cnt0 != 8'hFF)) begin
        grant_cnt0 <= grant_cnt0 + 8'h01;
      end
      if (req1_ready && (grant_cnt1 != 8'hFF)) begin
        grant_cnt1 <= grant_cnt1 + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 4;

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         f;
  } req_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         fl;
    logic         z;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_flagin;
  logic [W-1:0] req0_a, req0_b;
  logic [3:0]   req0_op;
  logic         req1_valid, req1_ready, req1_flagin;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_flags, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  alu_arbiter #(.Ancho(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_flagin(req0_flagin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_flagin(req1_flagin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  rsp_t exp_q[$];
  int   exp_cyc_q[$];
  int   grant_log[$];
  bit   model_idle = 1'b1;
  bit   model_last = 1'b1;
  bit   holding = 1'b0;
  rsp_t held;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain integer arithmetic from the opcode definitions.
  function automatic rsp_t ref_model(input logic id, input req_t r);
    int a, b, fin, res, fl, mask;
    rsp_t o;
    mask = (1 << W) - 1;
    a = int'(r.a);
    b = int'(r.b);
    fin = r.f ? 1 : 0;
    res = 0;
    fl = 0;
    o.err = 1'b0;
    case (int'(r.op))
      0: begin res = a + b;        fl = (res > mask) ? 1 : 0; end
      1: begin res = a + b + fin;  fl = (res > mask) ? 1 : 0; end
      2: begin res = a - b;        fl = (a < b) ? 1 : 0; end
      3: begin res = a - b - fin;  fl = (a < b + fin) ? 1 : 0; end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = ~a;
      8: begin res = (a << 1) | fin;           fl = (a >> (W - 1)) & 1; end
      9: begin res = (a >> 1) | (fin << (W-1)); fl = a & 1; end
      default: begin o.err = 1'b1; res = 0; fl = 0; end
    endcase
    res = res & mask;
    o.id  = id;
    o.res = W'(res);
    o.fl  = (fl != 0);
    o.z   = (res == 0);
    return o;
  endfunction

  function automatic req_t rnd_req(input bit valid);
    req_t r;
    r.v  = valid;
    r.a  = W'($urandom_range(0, (1 << W) - 1));
    r.b  = W'($urandom_range(0, (1 << W) - 1));
    r.op = 4'($urandom_range(0, 15));
    r.f  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One stimulus cycle: drive at the falling edge, check the combinational
  // readies against the arbitration rule, and queue the expected response.
  task automatic drive(input req_t r0, input req_t r1, input logic rr);
    bit g0, g1, gid;
    @(negedge clk);
    req0_valid = r0.v; req0_a = r0.a; req0_b = r0.b; req0_op = r0.op; req0_flagin = r0.f;
    req1_valid = r1.v; req1_a = r1.a; req1_b = r1.b; req1_op = r1.op; req1_flagin = r1.f;
    rsp_ready  = rr;
    #1;
    g0 = 1'b0; g1 = 1'b0; gid = 1'b0;
    if (model_idle && (r0.v || r1.v)) begin
      gid = (r0.v && r1.v) ? !model_last : r1.v;
      g0 = !gid;
      g1 = gid;
    end
    check("req0_ready", int'(req0_ready), int'(g0));
    check("req1_ready", int'(req1_ready), int'(g1));
    if (g0 || g1) begin
      exp_q.push_back(ref_model(gid, gid ? r1 : r0));
      exp_cyc_q.push_back(cyc + 2);
      grant_log.push_back(int'(gid));
      model_idle = 1'b0;
      model_last = gid;
    end
  endtask

  // Monitor: pops the scoreboard whenever a new response appears.
  initial begin
    rsp_t e, act;
    int   ec;
    forever begin
      @(negedge clk);
      #2;
      act = '{rsp_id, rsp_result, rsp_flags, rsp_zero, rsp_err};
      if (rsp_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
          end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("rsp_latency", cyc, ec);
            check("rsp_id", int'(rsp_id), int'(e.id));
            check("rsp_result", int'(rsp_result), int'(e.res));
            check("rsp_flags", int'(rsp_flags), int'(e.fl));
            check("rsp_zero", int'(rsp_zero), int'(e.z));
            check("rsp_err", int'(rsp_err), int'(e.err));
            held = act;
            holding = 1'b1;
          end
        end else begin
          check("rsp_stable", int'(act), int'(held));
        end
        if (rsp_ready) begin
          holding = 1'b0;
          model_idle = 1'b1;
        end
      end else if (exp_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got no rsp_valid expected response by cycle %0d", exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        model_idle = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_id"}, int'(rsp_id), 0);
    check({tag, "_rsp_result"}, int'(rsp_result), 0);
    check({tag, "_rsp_flags"}, int'(rsp_flags), 0);
    check({tag, "_rsp_zero"}, int'(rsp_zero), 0);
    check({tag, "_rsp_err"}, int'(rsp_err), 0);
    check({tag, "_req0_ready"}, int'(req0_ready), 0);
    check({tag, "_req1_ready"}, int'(req1_ready), 0);
`ifdef ALU_ARB_STATS_EN
    check({tag, "_grant_cnt0"}, int'(grant_cnt0), 0);
    check({tag, "_grant_cnt1"}, int'(grant_cnt1), 0);
`endif
  endtask

  req_t idle_r, ra, rb;
  int   n0;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt1_before;
`endif

  initial begin
    idle_r = '0;
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_flagin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_flagin = 0;
    rsp_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters always valid: grants alternate starting with req0.
    grant_log.delete();
    repeat (12) drive(rnd_req(1), rnd_req(1), 1'b1);
    repeat (3) drive(idle_r, idle_r, 1'b1);
    check("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) check("rr_grant_order", grant_log[i], i % 2);

    // Lone req0: 6 + 2 with ADD.
    ra = '{1'b1, 4'b0110, 4'b0010, 4'h0, 1'b0};
    drive(ra, idle_r, 1'b1);
    repeat (3) drive(idle_r, idle_r, 1'b1);

    // Response stalled for several cycles while both requesters wait.
    drive(idle_r, rnd_req(1), 1'b0);
    n0 = grant_log.size();
    repeat (7) drive(rnd_req(1), rnd_req(1), 1'b0);
    check("stall_no_grant", grant_log.size(), n0);
    drive(rnd_req(1), rnd_req(1), 1'b1);
    repeat (3) drive(idle_r, idle_r, 1'b1);

    // Illegal opcode from req1.
    rb = rnd_req(1);
    rb.op = 4'hC;
    drive(idle_r, rb, 1'b1);
    repeat (3) drive(idle_r, idle_r, 1'b1);

    // Reset while the operation is in EXEC.
    drive(rnd_req(1), idle_r, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    exp_q.delete();
    exp_cyc_q.delete();
    holding = 1'b0;
    model_idle = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) drive(idle_r, idle_r, 1'b1);

`ifdef ALU_ARB_STATS_EN
    drive(idle_r, rnd_req(1), 1'b1);
    repeat (2) drive(idle_r, idle_r, 1'b1);
    cnt1_before = grant_cnt1;
    repeat (300) begin
      drive(rnd_req(1), idle_r, 1'b1);
      repeat (2) drive(idle_r, idle_r, 1'b1);
    end
    drive(idle_r, idle_r, 1'b1);
    check("grant_cnt0_sat", int'(grant_cnt0), 255);
    check("grant_cnt1_held", int'(grant_cnt1), int'(cnt1_before));
`endif

    // Randomized traffic with valids that come and go.
    repeat (400) begin
      drive(rnd_req($urandom_range(0, 9) < 6), rnd_req($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive(idle_r, idle_r, 1'b1);
    repeat (2) drive(idle_r, idle_r, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
